// File: rtl/pwr_seq_ctrl_if.sv
// Write-port bundle between the host, the power sequencer and the register block.
// The sequencer is the slave on the host side and drives the register-block side.
interface pwr_seq_ctrl_if #(
   parameter int N = 27
);
   logic [7:0]   host_data;
   logic [N-1:0] host_valid_bus;
   logic         host_ready;
   logic [7:0]   master_data;
   logic [N-1:0] valid_bus;

   modport master (
      output host_data,
      output host_valid_bus,
      input  host_ready,
      input  master_data,
      input  valid_bus
   );

   modport slave (
      input  host_data,
      input  host_valid_bus,
      output host_ready,
      output master_data,
      output valid_bus
   );
endinterface

// File: rtl/pwr_seq_ctrl.sv
// Power-up / power-down sequencer sharing the register block's write port with host writes.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no sequence; host owns the write port
// S_UP_WR   | sequencer issues power-up table entry step_q next cycle
// S_UP_WAIT | inter-step delay after a power-up write
// S_DN_WR   | sequencer issues power-down table entry step_q next cycle
// S_DN_WAIT | inter-step delay after a power-down write
module pwr_seq_ctrl #(
   parameter int N        = 27,
   parameter int STEP_DLY = 1000,
   parameter int DLY_W    = 16
) (
   input  logic          clk,
   input  logic          rst,
   pwr_seq_ctrl_if.slave bus,
   input  logic          start_up,
   input  logic          start_dn,
   input  logic          err_clr,
   output logic          busy,
   output logic          done,
   output logic          pwr_on,
   output logic          err
);
   localparam int IDX_W = $clog2(N);
   localparam logic [N-1:0] P_MASK =
      N'((1 << 4) | (1 << 5) | (1 << 6) | (1 << 7) | (1 << 9) | (1 << 24) | (1 << 26));
   // WR itself is one of the STEP_DLY+1 cycles between strobes, so WAIT runs STEP_DLY-1 .. 0
   localparam logic [DLY_W-1:0] WAIT_LOAD = (STEP_DLY > 0) ? DLY_W'(STEP_DLY - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_UP_WR,
      S_UP_WAIT,
      S_DN_WR,
      S_DN_WAIT
   } state_t;

   state_t           state_q;
   logic [2:0]       step_q;
   logic [DLY_W-1:0] cnt_q;
   logic [7:0]       data_q;
   logic [N-1:0]     vbus_q;
   logic             done_q;
   logic             pwr_on_q;
   logic             err_q;

   logic [2:0]       tbl_step;
   logic [IDX_W-1:0] tbl_idx;
   logic             tbl_bit;
   logic [N-1:0]     seq_vbus_d;
   logic [7:0]       seq_data_d;
   logic             host_ready;
   logic             host_wr;
   logic             host_drop;
   logic             last_step;

   assign busy            = (state_q != S_IDLE);
   assign done            = done_q;
   assign pwr_on          = pwr_on_q;
   assign err             = err_q;
   assign host_ready      = !(state_q == S_UP_WR || state_q == S_DN_WR);
   assign bus.host_ready  = host_ready;
   assign bus.master_data = data_q;
   assign bus.valid_bus   = vbus_q;
   assign last_step       = (step_q == 3'd6);

   // Sequence table lookup; power-down walks the power-up table backwards with bit0 inverted
   always_comb begin
      tbl_step = (state_q == S_DN_WR) ? (3'd6 - step_q) : step_q;
      tbl_idx  = IDX_W'(26);
      tbl_bit  = 1'b1;
      case (tbl_step)
         3'd0:    begin tbl_idx = IDX_W'(7);  tbl_bit = 1'b0; end
         3'd1:    begin tbl_idx = IDX_W'(6);  tbl_bit = 1'b0; end
         3'd2:    begin tbl_idx = IDX_W'(5);  tbl_bit = 1'b0; end
         3'd3:    begin tbl_idx = IDX_W'(4);  tbl_bit = 1'b0; end
         3'd4:    begin tbl_idx = IDX_W'(9);  tbl_bit = 1'b0; end
         3'd5:    begin tbl_idx = IDX_W'(24); tbl_bit = 1'b1; end
         default: begin tbl_idx = IDX_W'(26); tbl_bit = 1'b1; end
      endcase
      seq_vbus_d          = '0;
      seq_vbus_d[tbl_idx] = 1'b1;
      seq_data_d          = {7'd0, tbl_bit ^ (state_q == S_DN_WR)};
   end

   // Host arbitration: sequenced registers are locked while any sequence is running
   always_comb begin
      host_wr   = host_ready && (bus.host_valid_bus != '0);
      host_drop = host_wr && busy && ((bus.host_valid_bus & P_MASK) != '0);
   end

   // Sequencer FSM with registered write port, status and error flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         step_q   <= 3'd0;
         cnt_q    <= '0;
         data_q   <= 8'd0;
         vbus_q   <= '0;
         done_q   <= 1'b0;
         pwr_on_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         vbus_q <= '0;

         if (host_wr && !host_drop) begin
            vbus_q <= bus.host_valid_bus;
            data_q <= bus.host_data;
         end

         if (host_drop) begin
            err_q <= 1'b1;
         end else if (err_clr) begin
            err_q <= 1'b0;
         end

         case (state_q)
            S_IDLE: begin
               if (start_dn) begin
                  state_q <= S_DN_WR;
                  step_q  <= 3'd0;
               end else if (start_up) begin
                  state_q <= S_UP_WR;
                  step_q  <= 3'd0;
               end
            end

            S_UP_WR: begin
               if (start_dn) begin
                  // step_q writes issued so far; undo exactly those
                  if (step_q == 3'd0) begin
                     state_q <= S_IDLE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_DN_WR;
                     step_q  <= 3'd7 - step_q;
                  end
               end else begin
                  vbus_q <= seq_vbus_d;
                  data_q <= seq_data_d;
                  if (STEP_DLY == 0) begin
                     if (last_step) begin
                        state_q  <= S_IDLE;
                        done_q   <= 1'b1;
                        pwr_on_q <= 1'b1;
                     end else begin
                        step_q <= step_q + 3'd1;
                     end
                  end else begin
                     cnt_q   <= WAIT_LOAD;
                     state_q <= S_UP_WAIT;
                  end
               end
            end

            S_UP_WAIT: begin
               if (start_dn) begin
                  // step_q+1 writes issued so far
                  state_q <= S_DN_WR;
                  step_q  <= 3'd6 - step_q;
               end else if (cnt_q == '0) begin
                  if (last_step) begin
                     state_q  <= S_IDLE;
                     done_q   <= 1'b1;
                     pwr_on_q <= 1'b1;
                  end else begin
                     step_q  <= step_q + 3'd1;
                     state_q <= S_UP_WR;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end

            S_DN_WR: begin
               vbus_q   <= seq_vbus_d;
               data_q   <= seq_data_d;
               pwr_on_q <= 1'b0;
               if (STEP_DLY == 0) begin
                  if (last_step) begin
                     state_q <= S_IDLE;
                     done_q  <= 1'b1;
                  end else begin
                     step_q <= step_q + 3'd1;
                  end
               end else begin
                  cnt_q   <= WAIT_LOAD;
                  state_q <= S_DN_WAIT;
               end
            end

            S_DN_WAIT: begin
               if (cnt_q == '0) begin
                  if (last_step) begin
                     state_q <= S_IDLE;
                     done_q  <= 1'b1;
                  end else begin
                     step_q  <= step_q + 3'd1;
                     state_q <= S_DN_WR;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Scoreboard bench for pwr_seq_ctrl with STEP_DLY=3 (sequencer strobes 4 cycles apart).
module tb_pwr_seq_ctrl;
   localparam int N = 27;

   typedef struct {
      int idx;
      int data;
      int gap;   // required cycles since last sequencer strobe, 0 = unchecked
      int pwr;   // required pwr_on at strobe, -1 = unchecked
      bit seq;   // sequencer-issued strobe
   } wr_t;

   logic clk = 1'b0;
   logic rst;
   logic start_up, start_dn, err_clr;
   logic busy, done, pwr_on, err;

   pwr_seq_ctrl_if #(.N(N)) bus ();

   pwr_seq_ctrl #(.N(N), .STEP_DLY(3), .DLY_W(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .start_up (start_up),
      .start_dn (start_dn),
      .err_clr  (err_clr),
      .busy     (busy),
      .done     (done),
      .pwr_on   (pwr_on),
      .err      (err)
   );

   always #5 clk = ~clk;

   int  passed = 0;
   int  total  = 0;
   int  cyc    = 0;
   int  last_seq_cyc = 0;
   wr_t exp_q[$];
   int  exp_done_q[$];
   int  up_idx[7] = '{7, 6, 5, 4, 9, 24, 26};
   int  up_dat[7] = '{0, 0, 0, 0, 0, 1, 1};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int idx, input int data, input int gap, input int pwr, input bit seq);
      wr_t e;
      e.idx = idx; e.data = data; e.gap = gap; e.pwr = pwr; e.seq = seq;
      exp_q.push_back(e);
   endtask

   // UP table steps [from..to]; first entry's spacing unchecked when first_gap==0
   task automatic push_up(input int from, input int to, input int first_gap, input int pwr);
      for (int k = from; k <= to; k++)
         push(up_idx[k], up_dat[k], (k == from) ? first_gap : 4, pwr, 1'b1);
   endtask

   task automatic push_dn(input int from, input int to, input int first_gap, input int pwr);
      for (int k = from; k <= to; k++)
         push(up_idx[6-k], up_dat[6-k] ^ 1, (k == from) ? first_gap : 4, pwr, 1'b1);
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 200 && (exp_q.size() != 0 || exp_done_q.size() != 0); i++) tick();
      chk({name, "_drain"}, exp_q.size() + exp_done_q.size(), 0);
      repeat (5) tick();
   endtask

   task automatic wait_strobes(input int k);
      int n = 0;
      for (int i = 0; i < 100 && n < k; i++) begin
         tick();
         if (bus.valid_bus != '0) n++;
      end
      chk("strobe_wait", n, k);
   endtask

   task automatic pulse_up();
      start_up = 1'b1;
      tick();
      start_up = 1'b0;
   endtask

   task automatic pulse_dn();
      start_dn = 1'b1;
      tick();
      start_dn = 1'b0;
   endtask

   // Monitor: compare every presented strobe and done pulse against the scoreboard
   initial begin
      wr_t e;
      logic [N-1:0] oh;
      forever begin
         @(negedge clk);
         cyc++;
         if (bus.valid_bus != '0) begin
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL unexpected_strobe: got valid_bus 0x%0h data 0x%0h expected none (cycle %0d)",
                        bus.valid_bus, bus.master_data, cyc);
            end else begin
               e = exp_q.pop_front();
               oh = '0;
               oh[e.idx] = 1'b1;
               chk("strobe_vbus", 32'(bus.valid_bus), 32'(oh));
               chk("strobe_data", 32'(bus.master_data), 32'(e.data));
               if (e.gap != 0) chk("strobe_gap", cyc - last_seq_cyc, e.gap);
               if (e.pwr >= 0) chk("strobe_pwr_on", 32'(pwr_on), 32'(e.pwr));
               if (e.seq) last_seq_cyc = cyc;
            end
         end
         if (done) begin
            if (exp_done_q.size() == 0) begin
               total++;
               $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
            end else begin
               chk("done_pwr_on", 32'(pwr_on), 32'(exp_done_q.pop_front()));
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      start_up = 1'b0; start_dn = 1'b0; err_clr = 1'b0;
      bus.host_data = 8'd0;
      bus.host_valid_bus = '0;
      repeat (3) tick();

      // reset state
      chk("rst_valid_bus", 32'(bus.valid_bus), 0);
      chk("rst_master_data", 32'(bus.master_data), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_pwr_on", 32'(pwr_on), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_host_ready", 32'(bus.host_ready), 1);
      rst = 1'b0;
      tick();

      // abort on the very first UP_WR: nothing issued, straight back to IDLE with done
      exp_done_q.push_back(0);
      pulse_up();
      chk("abort0_busy", 32'(busy), 1);
      pulse_dn();
      chk("abort0_idle", 32'(busy), 0);
      wait_drain("abort0");

      // full power-up
      push_up(0, 6, 0, 0);
      exp_done_q.push_back(1);
      pulse_up();
      wait_drain("up");
      chk("up_pwr_on", 32'(pwr_on), 1);
      chk("up_busy", 32'(busy), 0);

      // full power-down
      push_dn(0, 6, 0, 0);
      exp_done_q.push_back(0);
      pulse_dn();
      wait_drain("dn");
      chk("dn_pwr_on", 32'(pwr_on), 0);

      // abort after three UP writes undoes just those three
      push_up(0, 2, 0, 0);
      push_dn(4, 6, 0, 0);
      exp_done_q.push_back(0);
      pulse_up();
      wait_strobes(3);
      tick();
      pulse_dn();
      wait_drain("abort3");

      // host traffic during a power-up: unprotected passes, protected dropped
      push_up(0, 0, 0, 0);
      pulse_up();
      wait_strobes(1);
      push(11, 8'h4B, 1, -1, 1'b0);
      push_up(1, 6, 4, 0);
      exp_done_q.push_back(1);
      chk("host_ready_wait", 32'(bus.host_ready), 1);
      bus.host_valid_bus = N'(1) << 11;
      bus.host_data = 8'h4B;
      tick();
      bus.host_valid_bus = N'(1) << 5;
      bus.host_data = 8'h77;
      tick();
      bus.host_valid_bus = '0;
      bus.host_data = 8'h00;
      chk("err_set", 32'(err), 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("err_clr", 32'(err), 0);
      wait_drain("host");

      // host write presented in UP_WR is held off one cycle; start_up with pwr_on=1 still runs
      push_up(0, 0, 0, 1);
      push(12, 8'h5A, 1, -1, 1'b0);
      push_up(1, 6, 4, 1);
      exp_done_q.push_back(1);
      pulse_up();
      bus.host_valid_bus = N'(1) << 12;
      bus.host_data = 8'h5A;
      chk("host_ready_wr", 32'(bus.host_ready), 0);
      tick();
      chk("host_ready_after_wr", 32'(bus.host_ready), 1);
      tick();
      bus.host_valid_bus = '0;
      bus.host_data = 8'h00;
      wait_drain("held");

      // simultaneous start in IDLE: power-down wins
      push_dn(0, 6, 0, 0);
      exp_done_q.push_back(0);
      start_up = 1'b1;
      start_dn = 1'b1;
      tick();
      start_up = 1'b0;
      start_dn = 1'b0;
      wait_drain("both");

      // reset in the middle of UP_WAIT stops the sequence dead
      push_up(0, 0, 0, 0);
      pulse_up();
      wait_strobes(1);
      tick();
      rst = 1'b1;
      tick();
      chk("midrst_valid_bus", 32'(bus.valid_bus), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_done", 32'(done), 0);
      chk("midrst_pwr_on", 32'(pwr_on), 0);
      chk("midrst_master_data", 32'(bus.master_data), 0);
      rst = 1'b0;
      repeat (30) tick();
      chk("midrst_idle", 32'(busy), 0);
      chk("midrst_queue", exp_q.size() + exp_done_q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
